// File: rtl/rs_pipeline_tail_fifo.sv
// Tail buffer of a relay-station pipeline: stores every in-flight word and returns
// a registered almost-full credit that travels back through the backward stages.
module rs_pipeline_tail_fifo #(
    parameter int unsigned DATA_WIDTH     = 32,
    parameter int unsigned PIPELINE_LEVEL = 6,
    parameter int unsigned DEPTH          = 32,
    localparam int unsigned GRACE         = 2 * PIPELINE_LEVEL + 2,
    localparam int unsigned ADDR_WIDTH    = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    input  logic [DATA_WIDTH-1:0] in_data,
    output logic                  in_full_n,
    output logic                  out_valid,
    output logic [DATA_WIDTH-1:0] out_data,
    input  logic                  out_ready,
    output logic [ADDR_WIDTH:0]   occupancy,
    output logic                  overflow
);

    localparam logic [ADDR_WIDTH:0]   DEPTH_CNT = (ADDR_WIDTH + 1)'(DEPTH);
    localparam logic [ADDR_WIDTH:0]   THRESHOLD = (ADDR_WIDTH + 1)'(DEPTH - GRACE);
    localparam logic [ADDR_WIDTH:0]   OCC_ONE   = (ADDR_WIDTH + 1)'(1);
    localparam logic [ADDR_WIDTH-1:0] PTR_ONE   = ADDR_WIDTH'(1);

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [ADDR_WIDTH-1:0] wr_ptr_q;
    logic [ADDR_WIDTH-1:0] rd_ptr_q;
    logic [ADDR_WIDTH:0]   occ_q;
    logic [ADDR_WIDTH:0]   occ_d;
    logic                  full_n_q;
    logic                  ovf_q;
    logic                  full;
    logic                  push;
    logic                  pop;

    always_comb begin
        full  = (occ_q == DEPTH_CNT);
        pop   = (occ_q != '0) && out_ready;
        // A pop in the same cycle frees a slot, so a write at full is still taken.
        push  = in_valid && (!full || pop);
        occ_d = occ_q;
        case ({push, pop})
            2'b10:   occ_d = occ_q + OCC_ONE;
            2'b01:   occ_d = occ_q - OCC_ONE;
            default: occ_d = occ_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            occ_q    <= '0;
            full_n_q <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + PTR_ONE;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_ONE;
            end
            occ_q    <= occ_d;
            full_n_q <= (occ_d < THRESHOLD);
            if (in_valid && full && !pop) begin
                ovf_q <= 1'b1;
            end
        end
    end

    // Storage carries no reset; contents are only observed through occupancy.
    always_ff @(posedge clk) begin
        if (rst_n && push) begin
            mem_q[wr_ptr_q] <= in_data;
        end
    end

    assign in_full_n = full_n_q;
    assign out_valid = (occ_q != '0);
    assign out_data  = mem_q[rd_ptr_q];
    assign occupancy = occ_q;
    assign overflow  = ovf_q;

endmodule

// File: tb/tb_rs_pipeline_tail_fifo.sv
// Directed bench for rs_pipeline_tail_fifo with DEPTH=32, PIPELINE_LEVEL=6 (threshold 18).
module tb_rs_pipeline_tail_fifo;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic [31:0] in_data;
    logic        in_full_n;
    logic        out_valid;
    logic [31:0] out_data;
    logic        out_ready;
    logic [5:0]  occupancy;
    logic        overflow;

    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;

    rs_pipeline_tail_fifo #(
        .DATA_WIDTH    (32),
        .PIPELINE_LEVEL(6),
        .DEPTH         (32)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_data  (in_data),
        .in_full_n(in_full_n),
        .out_valid(out_valid),
        .out_data (out_data),
        .out_ready(out_ready),
        .occupancy(occupancy),
        .overflow (overflow)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        step();
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_reset();
        rst_n     = 1'b0;
        in_valid  = 1'b1;
        in_data   = 32'hDEAD_BEEF;
        out_ready = 1'b0;
        for (int c = 0; c < 3; c++) begin
            step();
            n_checks++;
            if (occupancy !== 6'd0) $display("FAIL rst_occ: got %0d want 0", occupancy);
            else n_pass++;
            n_checks++;
            if (out_valid !== 1'b0) $display("FAIL rst_out_valid: got %b want 0", out_valid);
            else n_pass++;
            n_checks++;
            if (overflow !== 1'b0) $display("FAIL rst_overflow: got %b want 0", overflow);
            else n_pass++;
            n_checks++;
            if (in_full_n !== 1'b0) $display("FAIL rst_full_n: got %b want 0", in_full_n);
            else n_pass++;
        end
        rst_n    = 1'b1;
        in_valid = 1'b0;
        step();
        n_checks++;
        if (in_full_n !== 1'b1) $display("FAIL rel_full_n: got %b want 1", in_full_n);
        else n_pass++;
        n_checks++;
        if (occupancy !== 6'd0) $display("FAIL rel_occ: got %0d want 0", occupancy);
        else n_pass++;
    endtask

    task automatic test_single_word();
        in_valid  = 1'b1;
        in_data   = 32'hA5A5_0001;
        out_ready = 1'b0;
        step();
        in_valid = 1'b0;
        for (int c = 0; c < 6; c++) begin
            n_checks++;
            if (out_valid !== 1'b1 || out_data !== 32'hA5A5_0001)
                $display("FAIL single_hold[%0d]: got v=%b d=%h want v=1 d=a5a50001",
                         c, out_valid, out_data);
            else n_pass++;
            if (c < 5) step();
        end
        n_checks++;
        if (occupancy !== 6'd1) $display("FAIL single_occ: got %0d want 1", occupancy);
        else n_pass++;
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        n_checks++;
        if (out_valid !== 1'b0 || occupancy !== 6'd0)
            $display("FAIL single_pop: got v=%b occ=%0d want v=0 occ=0", out_valid, occupancy);
        else n_pass++;
    endtask

    task automatic test_threshold();
        out_ready = 1'b0;
        for (int i = 0; i < 32; i++) begin
            in_valid = 1'b1;
            in_data  = i;
            step();
            if (i == 16) begin
                n_checks++;
                if (in_full_n !== 1'b1 || occupancy !== 6'd17)
                    $display("FAIL thr_17: got fn=%b occ=%0d want fn=1 occ=17",
                             in_full_n, occupancy);
                else n_pass++;
            end
            if (i == 17) begin
                n_checks++;
                if (in_full_n !== 1'b0 || occupancy !== 6'd18)
                    $display("FAIL thr_18: got fn=%b occ=%0d want fn=0 occ=18",
                             in_full_n, occupancy);
                else n_pass++;
            end
        end
        in_valid = 1'b0;
        n_checks++;
        if (occupancy !== 6'd32) $display("FAIL thr_occ32: got %0d want 32", occupancy);
        else n_pass++;
        n_checks++;
        if (overflow !== 1'b0) $display("FAIL thr_ovf: got %b want 0", overflow);
        else n_pass++;
        n_checks++;
        if (in_full_n !== 1'b0) $display("FAIL thr_full_n: got %b want 0", in_full_n);
        else n_pass++;
        n_checks++;
        if (out_valid !== 1'b1 || out_data !== 32'd0)
            $display("FAIL thr_head: got v=%b d=%0d want v=1 d=0", out_valid, out_data);
        else n_pass++;
    endtask

    task automatic test_full_push_pop();
        in_valid  = 1'b1;
        in_data   = 32'd32;
        out_ready = 1'b1;
        step();
        n_checks++;
        if (occupancy !== 6'd32 || overflow !== 1'b0 || out_data !== 32'd1)
            $display("FAIL full_pp: got occ=%0d ovf=%b d=%0d want occ=32 ovf=0 d=1",
                     occupancy, overflow, out_data);
        else n_pass++;
        in_data   = 32'd33;
        out_ready = 1'b0;
        step();
        in_valid = 1'b0;
        n_checks++;
        if (overflow !== 1'b1 || occupancy !== 6'd32 || out_data !== 32'd1)
            $display("FAIL full_drop: got ovf=%b occ=%0d d=%0d want ovf=1 occ=32 d=1",
                     overflow, occupancy, out_data);
        else n_pass++;
        repeat (3) step();
        n_checks++;
        if (overflow !== 1'b1) $display("FAIL ovf_sticky: got %b want 1", overflow);
        else n_pass++;
        out_ready = 1'b1;
        for (int k = 1; k <= 32; k++) begin
            n_checks++;
            if (out_valid !== 1'b1 || out_data !== k)
                $display("FAIL drain[%0d]: got v=%b d=%0d want v=1 d=%0d",
                         k, out_valid, out_data, k);
            else n_pass++;
            step();
        end
        out_ready = 1'b0;
        n_checks++;
        if (occupancy !== 6'd0 || out_valid !== 1'b0 || in_full_n !== 1'b1)
            $display("FAIL drain_end: got occ=%0d v=%b fn=%b want occ=0 v=0 fn=1",
                     occupancy, out_valid, in_full_n);
        else n_pass++;
        n_checks++;
        if (overflow !== 1'b1) $display("FAIL ovf_after_drain: got %b want 1", overflow);
        else n_pass++;
    endtask

    task automatic test_wrap();
        out_ready = 1'b1;
        for (int i = 0; i < 100; i++) begin
            in_valid = 1'b1;
            in_data  = 32'h1000 + i;
            step();
            n_checks++;
            if (out_valid !== 1'b1 || out_data !== 32'h1000 + i || occupancy !== 6'd1)
                $display("FAIL wrap[%0d]: got v=%b d=%h occ=%0d want v=1 d=%h occ=1",
                         i, out_valid, out_data, occupancy, 32'h1000 + i);
            else n_pass++;
        end
        in_valid = 1'b0;
        step();
        out_ready = 1'b0;
        n_checks++;
        if (occupancy !== 6'd0) $display("FAIL wrap_end: got %0d want 0", occupancy);
        else n_pass++;
    endtask

    task automatic test_round_trip();
        logic        fwd_v [6];
        logic [31:0] fwd_d [6];
        logic        bwd   [6];
        int unsigned tx = 0;
        int unsigned rx = 0;
        int unsigned cyc = 0;
        logic        send;
        bit          ovf_seen = 1'b0;
        for (int i = 0; i < 6; i++) begin
            fwd_v[i] = 1'b0;
            fwd_d[i] = '0;
            bwd[i]   = 1'b0;
        end
        while (rx < 10000 && cyc < 80000) begin
            in_valid  = fwd_v[5];
            in_data   = fwd_d[5];
            out_ready = 1'($urandom_range(0, 1));
            if (out_valid && out_ready) begin
                n_checks++;
                if (out_data !== rx) $display("FAIL rt_order[%0d]: got %0d want %0d",
                                              rx, out_data, rx);
                else n_pass++;
                rx++;
            end
            if (overflow) ovf_seen = 1'b1;
            // Next-state of the relay stages, as captured by the coming edge.
            send = bwd[5] && (tx < 10000);
            for (int i = 5; i > 0; i--) begin
                fwd_v[i] = fwd_v[i-1];
                fwd_d[i] = fwd_d[i-1];
                bwd[i]   = bwd[i-1];
            end
            fwd_v[0] = send;
            fwd_d[0] = tx;
            bwd[0]   = in_full_n;
            if (send) tx++;
            step();
            cyc++;
        end
        in_valid  = 1'b0;
        out_ready = 1'b0;
        n_checks++;
        if (rx !== 10000) $display("FAIL rt_count: got %0d want 10000", rx);
        else n_pass++;
        n_checks++;
        if (ovf_seen || overflow !== 1'b0) $display("FAIL rt_overflow: got 1 want 0");
        else n_pass++;
    endtask

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;
        test_reset();
        test_single_word();
        test_threshold();
        test_full_push_pop();
        do_reset();
        test_wrap();
        test_round_trip();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
